// File: rtl/fpu_cmp_sgnj_unit.sv
// rtl/fpu_cmp_sgnj_unit.sv - pipelined FP min/max, compare, sign-injection and classify unit
// Result is computed at accept; the remaining stages only delay it under a valid/ready chain.
module fpu_cmp_sgnj_unit #(
   parameter int EXP_W   = 5,
   parameter int FRAC_W  = 10,
   parameter int XLEN_W  = 32,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [XLEN_W-1:0] in_rs1,
   input  logic [XLEN_W-1:0] in_rs2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_nv,
   output logic              out_ill
);

   localparam int FLEN = 1 + EXP_W + FRAC_W;

   localparam logic [3:0] OP_MIN   = 4'd0;
   localparam logic [3:0] OP_MAX   = 4'd1;
   localparam logic [3:0] OP_FEQ   = 4'd2;
   localparam logic [3:0] OP_FLT   = 4'd3;
   localparam logic [3:0] OP_FLE   = 4'd4;
   localparam logic [3:0] OP_SGNJ  = 4'd5;
   localparam logic [3:0] OP_SGNJN = 4'd6;
   localparam logic [3:0] OP_SGNJX = 4'd7;
   localparam logic [3:0] OP_CLASS = 4'd8;

   localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef struct packed {
      logic [XLEN_W-1:0] result;
      logic [TAG_W-1:0]  tag;
      logic              nv;
      logic              ill;
   } stage_t;

   function automatic logic [XLEN_W-1:0] sext(input logic [FLEN-1:0] v);
      return XLEN_W'(signed'(v));
   endfunction

   // Only the low FLEN bits of each register carry the operand.
   logic unused_hi_bits;
   assign unused_hi_bits = ^{in_rs1, in_rs2};

   logic [FLEN-1:0]   a, b;
   logic              a_sign, b_sign;
   logic [EXP_W-1:0]  a_exp, b_exp;
   logic [FRAC_W-1:0] a_frac, b_frac;
   logic [FLEN-2:0]   a_mag, b_mag;

   assign a      = in_rs1[FLEN-1:0];
   assign b      = in_rs2[FLEN-1:0];
   assign a_sign = a[FLEN-1];
   assign b_sign = b[FLEN-1];
   assign a_exp  = a[FLEN-2:FRAC_W];
   assign b_exp  = b[FLEN-2:FRAC_W];
   assign a_frac = a[FRAC_W-1:0];
   assign b_frac = b[FRAC_W-1:0];
   assign a_mag  = a[FLEN-2:0];
   assign b_mag  = b[FLEN-2:0];

   logic a_exp_max, a_exp_zero, a_frac_zero, b_exp_max, b_exp_zero, b_frac_zero;
   logic a_nan, a_snan, a_qnan, a_inf, a_zero, a_sub, a_norm;
   logic b_nan, b_snan, b_zero;

   assign a_exp_max   = &a_exp;
   assign a_exp_zero  = ~|a_exp;
   assign a_frac_zero = ~|a_frac;
   assign b_exp_max   = &b_exp;
   assign b_exp_zero  = ~|b_exp;
   assign b_frac_zero = ~|b_frac;

   assign a_nan  = a_exp_max & ~a_frac_zero;
   assign a_snan = a_nan & ~a_frac[FRAC_W-1];
   assign a_qnan = a_nan & a_frac[FRAC_W-1];
   assign a_inf  = a_exp_max & a_frac_zero;
   assign a_zero = a_exp_zero & a_frac_zero;
   assign a_sub  = a_exp_zero & ~a_frac_zero;
   assign a_norm = ~a_exp_zero & ~a_exp_max;
   assign b_nan  = b_exp_max & ~b_frac_zero;
   assign b_snan = b_nan & ~b_frac[FRAC_W-1];
   assign b_zero = b_exp_zero & b_frac_zero;

   logic any_nan, any_snan, both_zero, lt_total;
   logic feq, flt, fle;
   logic [FLEN-1:0] min_val, max_val;
   logic [9:0]      cls;

   assign any_nan   = a_nan | b_nan;
   assign any_snan  = a_snan | b_snan;
   assign both_zero = a_zero & b_zero;

   // Total order over non-NaN values in which -0 sorts below +0.
   assign lt_total = (a_sign != b_sign) ? a_sign
                   : (a_sign ? (a_mag > b_mag) : (a_mag < b_mag));

   assign feq = ~any_nan & ((a == b) | both_zero);
   assign flt = ~any_nan & lt_total & ~both_zero;
   assign fle = flt | feq;

   always_comb begin
      min_val = lt_total ? a : b;
      max_val = lt_total ? b : a;
      if (a_nan && b_nan) begin
         min_val = CANON_NAN;
         max_val = CANON_NAN;
      end else if (a_nan) begin
         min_val = b;
         max_val = b;
      end else if (b_nan) begin
         min_val = a;
         max_val = a;
      end
   end

   assign cls = {a_qnan, a_snan,
                 ~a_sign & a_inf, ~a_sign & a_norm, ~a_sign & a_sub, ~a_sign & a_zero,
                 a_sign & a_zero, a_sign & a_sub, a_sign & a_norm, a_sign & a_inf};

   stage_t new_stage;

   always_comb begin
      new_stage     = '0;
      new_stage.tag = in_tag;
      case (in_op)
         OP_MIN: begin
            new_stage.result = sext(min_val);
            new_stage.nv     = any_snan;
         end
         OP_MAX: begin
            new_stage.result = sext(max_val);
            new_stage.nv     = any_snan;
         end
         OP_FEQ: begin
            new_stage.result = XLEN_W'(feq);
            new_stage.nv     = any_snan;
         end
         OP_FLT: begin
            new_stage.result = XLEN_W'(flt);
            new_stage.nv     = any_nan;
         end
         OP_FLE: begin
            new_stage.result = XLEN_W'(fle);
            new_stage.nv     = any_nan;
         end
         OP_SGNJ:  new_stage.result = sext({b_sign, a_mag});
         OP_SGNJN: new_stage.result = sext({~b_sign, a_mag});
         OP_SGNJX: new_stage.result = sext({a_sign ^ b_sign, a_mag});
         OP_CLASS: new_stage.result = XLEN_W'(cls);
         default:  new_stage.ill    = 1'b1;
      endcase
   end

   stage_t             stg [LATENCY];
   logic [LATENCY-1:0] stg_valid;
   logic [LATENCY-1:0] stg_ld;

   // A stage may load when it is empty or its content leaves this cycle; walk back from the output.
   always_comb begin
      logic acc;
      stg_ld = '0;
      acc    = out_ready;
      for (int i = LATENCY - 1; i >= 0; i--) begin
         acc       = ~stg_valid[i] | acc;
         stg_ld[i] = acc;
      end
   end

   assign in_ready = stg_ld[0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         stg_valid <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            stg[i] <= '0;
         end
      end else begin
         if (stg_ld[0]) begin
            stg_valid[0] <= in_valid;
            if (in_valid) begin
               stg[0] <= new_stage;
            end
         end
         for (int i = 1; i < LATENCY; i++) begin
            if (stg_ld[i]) begin
               stg_valid[i] <= stg_valid[i-1];
               if (stg_valid[i-1]) begin
                  stg[i] <= stg[i-1];
               end
            end
         end
      end
   end

   assign out_valid  = stg_valid[LATENCY-1];
   assign out_result = stg[LATENCY-1].result;
   assign out_tag    = stg[LATENCY-1].tag;
   assign out_nv     = stg[LATENCY-1].nv;
   assign out_ill    = stg[LATENCY-1].ill;

endmodule

// File: tb/tb_fpu_cmp_sgnj_unit.sv
// tb/tb_fpu_cmp_sgnj_unit.sv - bench for fpu_cmp_sgnj_unit in half (LATENCY 2) and single (LATENCY 1) configurations
`timescale 1ns/1ps
module tb_fpu_cmp_sgnj_unit;

   localparam int LAT = 2;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic        in_valid, in_ready, out_valid, out_ready, out_nv, out_ill;
   logic [3:0]  in_op, in_tag, out_tag;
   logic [31:0] in_rs1, in_rs2, out_result;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_nv, s_out_ill;
   logic [3:0]  s_in_op, s_in_tag, s_out_tag;
   logic [63:0] s_in_rs1, s_in_rs2, s_out_result;

   fpu_cmp_sgnj_unit #(.EXP_W(5), .FRAC_W(10), .XLEN_W(32), .LATENCY(LAT), .TAG_W(4)) dut_h (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_nv(out_nv), .out_ill(out_ill)
   );

   fpu_cmp_sgnj_unit #(.EXP_W(8), .FRAC_W(23), .XLEN_W(64), .LATENCY(1), .TAG_W(4)) dut_s (
      .CLK(CLK), .RST(RST),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
      .in_rs1(s_in_rs1), .in_rs2(s_in_rs2), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
      .out_tag(s_out_tag), .out_nv(s_out_nv), .out_ill(s_out_ill)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        nv;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        nv;
      logic        ill;
      int          acc_cyc;
      logic        chk_lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   exp_t cur_exp, pushed, popped;
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic nv, input logic ill);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.nv = nv; v.ill = ill;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // Scoreboard: pop on output transfer before pushing this cycle's accept, so stale outputs are caught.
   always @(negedge CLK) begin
      if (RST) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            cmp_cnt++;
            if (sb_q.size() == 0) begin
               err_cnt++;
               $display("FAIL unexpected_output: got result=%h tag=%0d, required no output", out_result, out_tag);
            end else begin
               popped = sb_q.pop_front();
               if (out_result !== popped.res || out_tag !== popped.tag || out_nv !== popped.nv ||
                   out_ill !== popped.ill || (popped.chk_lat && (cyc - popped.acc_cyc != LAT))) begin
                  err_cnt++;
                  $display("FAIL scoreboard: got result=%h tag=%0d nv=%b ill=%b lat=%0d, required result=%h tag=%0d nv=%b ill=%b lat=%0d",
                           out_result, out_tag, out_nv, out_ill, cyc - popped.acc_cyc,
                           popped.res, popped.tag, popped.nv, popped.ill, LAT);
               end
            end
         end
         if (in_valid && in_ready) begin
            pushed         = cur_exp;
            pushed.acc_cyc = cyc;
            sb_q.push_back(pushed);
         end
      end
   end

   task automatic drive(input vec_t v, input logic [3:0] tag, input logic chk);
      in_op = v.op; in_rs1 = v.a; in_rs2 = v.b; in_tag = tag; in_valid = 1'b1;
      cur_exp.res = v.res; cur_exp.tag = tag; cur_exp.nv = v.nv; cur_exp.ill = v.ill;
      cur_exp.acc_cyc = 0; cur_exp.chk_lat = chk;
   endtask

   task automatic send(input vec_t v, input logic [3:0] tag, input logic chk, output int tries);
      logic acc;
      acc   = 1'b0;
      tries = 0;
      drive(v, tag, chk);
      while (!acc && tries < 50) begin
         @(negedge CLK);
         acc = in_ready;
         @(posedge CLK);
         #1;
         tries++;
      end
      if (!acc) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", tries);
      end
   endtask

   task automatic check_sp(input string name, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_res, input logic exp_nv);
      s_in_op = op; s_in_rs1 = a; s_in_rs2 = b; s_in_tag = 4'hA; s_in_valid = 1'b1;
      @(negedge CLK);
      check({name, "_accept"}, 64'(s_in_ready), 64'd1);
      @(posedge CLK);
      #1;
      s_in_valid = 1'b0;
      @(negedge CLK);
      cmp_cnt++;
      if (!(s_out_valid === 1'b1 && s_out_result === exp_res && s_out_nv === exp_nv && s_out_tag === 4'hA)) begin
         err_cnt++;
         $display("FAIL %s: got valid=%b result=%h nv=%b tag=%h, required valid=1 result=%h nv=%b tag=a",
                  name, s_out_valid, s_out_result, s_out_nv, s_out_tag, exp_res, exp_nv);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int tries;
      logic [31:0] held;
      RST = 1'b1;
      in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_tag = 0; out_ready = 1'b1;
      s_in_valid = 0; s_in_op = 0; s_in_rs1 = 0; s_in_rs2 = 0; s_in_tag = 0; s_out_ready = 1'b1;

      vecs.push_back(mk(4'd0, 32'h3C00, 32'hC000, 32'hFFFFC000, 0, 0));
      vecs.push_back(mk(4'd0, 32'h0000, 32'h8000, 32'hFFFF8000, 0, 0));
      vecs.push_back(mk(4'd1, 32'h0000, 32'h8000, 32'h00000000, 0, 0));
      vecs.push_back(mk(4'd1, 32'h7D00, 32'h7E00, 32'h00007E00, 1, 0));
      vecs.push_back(mk(4'd1, 32'h7D00, 32'h3C00, 32'h00003C00, 1, 0));
      vecs.push_back(mk(4'd0, 32'h7E00, 32'h3C00, 32'h00003C00, 0, 0));
      vecs.push_back(mk(4'd0, 32'hFC00, 32'h7C00, 32'hFFFFFC00, 0, 0));
      vecs.push_back(mk(4'd1, 32'hC000, 32'hBC00, 32'hFFFFBC00, 0, 0));
      vecs.push_back(mk(4'd0, 32'hABCD3C00, 32'h1234C000, 32'hFFFFC000, 0, 0));
      vecs.push_back(mk(4'd3, 32'h7E00, 32'h3C00, 32'h0, 1, 0));
      vecs.push_back(mk(4'd2, 32'h7E00, 32'h3C00, 32'h0, 0, 0));
      vecs.push_back(mk(4'd2, 32'h7D00, 32'h3C00, 32'h0, 1, 0));
      vecs.push_back(mk(4'd4, 32'h8000, 32'h0000, 32'h1, 0, 0));
      vecs.push_back(mk(4'd2, 32'h3C00, 32'h3C00, 32'h1, 0, 0));
      vecs.push_back(mk(4'd2, 32'h0000, 32'h8000, 32'h1, 0, 0));
      vecs.push_back(mk(4'd3, 32'h8000, 32'h0000, 32'h0, 0, 0));
      vecs.push_back(mk(4'd3, 32'hC000, 32'h3C00, 32'h1, 0, 0));
      vecs.push_back(mk(4'd3, 32'h3C00, 32'h3C00, 32'h0, 0, 0));
      vecs.push_back(mk(4'd4, 32'h3C00, 32'h3C00, 32'h1, 0, 0));
      vecs.push_back(mk(4'd8, 32'hFC00, 32'h0, 32'h001, 0, 0));
      vecs.push_back(mk(4'd8, 32'h0001, 32'h0, 32'h020, 0, 0));
      vecs.push_back(mk(4'd8, 32'h8000, 32'h0, 32'h008, 0, 0));
      vecs.push_back(mk(4'd8, 32'h7D00, 32'h0, 32'h100, 0, 0));
      vecs.push_back(mk(4'd8, 32'h7E00, 32'h0, 32'h200, 0, 0));
      vecs.push_back(mk(4'd8, 32'h3C00, 32'h0, 32'h040, 0, 0));
      vecs.push_back(mk(4'd8, 32'h7C00, 32'h0, 32'h080, 0, 0));
      vecs.push_back(mk(4'd8, 32'h8001, 32'h0, 32'h004, 0, 0));
      vecs.push_back(mk(4'd8, 32'hBC00, 32'h0, 32'h002, 0, 0));
      vecs.push_back(mk(4'd8, 32'h0000, 32'h0, 32'h010, 0, 0));
      vecs.push_back(mk(4'd7, 32'hBC00, 32'hC000, 32'h00003C00, 0, 0));
      vecs.push_back(mk(4'd5, 32'h3C00, 32'h8000, 32'hFFFFBC00, 0, 0));
      vecs.push_back(mk(4'd6, 32'h3C00, 32'h8000, 32'h00003C00, 0, 0));
      vecs.push_back(mk(4'd6, 32'h7D00, 32'h0000, 32'hFFFFFD00, 0, 0));
      vecs.push_back(mk(4'd12, 32'h3C00, 32'h3C00, 32'h0, 0, 1));
      vecs.push_back(mk(4'd15, 32'h7D00, 32'h7D00, 32'h0, 0, 1));

      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check("reset_outputs", {out_valid, out_result, out_tag, out_nv, out_ill, in_ready},
            {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1});
      check("reset_outputs_sp", {s_out_valid, s_out_tag, s_out_nv, s_out_ill, s_in_ready}, {1'b0, 4'h0, 3'b001});
      check("reset_result_sp", s_out_result, 64'h0);
      @(posedge CLK);
      #1;

      // Free-flowing table: one op per cycle, each must be accepted on first offer.
      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i], 4'(i), 1'b1, tries);
         check("accept_first_offer", 64'(tries), 64'd1);
      end
      in_valid = 1'b0;
      repeat (LAT + 2) @(posedge CLK);
      #1;
      check("table_drained", 64'(sb_q.size()), 64'd0);

      // Backpressure: two ops fill the pipe, the third offer is refused until out_ready rises.
      out_ready = 1'b0;
      drive(mk(4'd0, 32'h3C00, 32'hC000, 32'hFFFFC000, 0, 0), 4'd1, 1'b0);
      @(negedge CLK); check("bp_ready_tag1", 64'(in_ready), 64'd1);
      @(posedge CLK); #1;
      drive(mk(4'd2, 32'h3C00, 32'h3C00, 32'h1, 0, 0), 4'd2, 1'b0);
      @(negedge CLK); check("bp_ready_tag2", 64'(in_ready), 64'd1);
      @(posedge CLK); #1;
      drive(mk(4'd8, 32'h7E00, 32'h0, 32'h200, 0, 0), 4'd3, 1'b0);
      @(negedge CLK);
      check("bp_full_tag3", 64'(in_ready), 64'd0);
      check("bp_head_tag", {out_valid, out_tag}, {1'b1, 4'd1});
      held = out_result;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("bp_still_full", 64'(in_ready), 64'd0);
      check("bp_held_stable", {out_valid, out_tag, out_result}, {1'b1, 4'd1, held});
      @(posedge CLK); #1;
      out_ready = 1'b1;
      @(negedge CLK);
      check("drain_out1", {out_valid, out_tag, in_ready}, {1'b1, 4'd1, 1'b1});
      @(posedge CLK); #1;
      drive(mk(4'd6, 32'h3C00, 32'h8000, 32'h00003C00, 0, 0), 4'd4, 1'b0);
      @(negedge CLK);
      check("drain_out2", {out_valid, out_tag, in_ready}, {1'b1, 4'd2, 1'b1});
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK); check("drain_out3", {out_valid, out_tag}, {1'b1, 4'd3});
      @(posedge CLK); #1;
      @(negedge CLK); check("drain_out4", {out_valid, out_tag}, {1'b1, 4'd4});
      @(posedge CLK); #1;
      @(negedge CLK); check("drain_empty", 64'(out_valid), 64'd0);
      @(posedge CLK); #1;

      // Reset with two ops in flight.
      out_ready = 1'b0;
      send(mk(4'd0, 32'h0000, 32'h8000, 32'hFFFF8000, 0, 0), 4'd5, 1'b0, tries);
      send(mk(4'd1, 32'h7D00, 32'h3C00, 32'h00003C00, 1, 0), 4'd6, 1'b0, tries);
      in_valid = 1'b0;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("post_reset_outputs", {out_valid, out_result, out_tag, out_nv, out_ill, in_ready},
            {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1});
      @(posedge CLK); #1;
      out_ready = 1'b1;
      send(mk(4'd3, 32'hC000, 32'h3C00, 32'h1, 0, 0), 4'd7, 1'b1, tries);
      in_valid = 1'b0;
      repeat (LAT + 3) @(posedge CLK);
      #1;
      @(negedge CLK);
      check("post_reset_drained", {32'(sb_q.size()), 31'h0, out_valid}, 64'h0);
      @(posedge CLK); #1;

      check_sp("sp_min", 4'd0, 64'h3F800000, 64'hC0000000, 64'hFFFFFFFFC0000000, 1'b0);
      check_sp("sp_min_zero", 4'd0, 64'h00000000, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
      check_sp("sp_flt_nan", 4'd3, 64'h7FC00000, 64'h3F800000, 64'h0, 1'b1);
      check_sp("sp_flt", 4'd3, 64'hBF800000, 64'h3F800000, 64'h1, 1'b0);
      check_sp("sp_class_ninf", 4'd8, 64'hFF800000, 64'h0, 64'h001, 1'b0);
      check_sp("sp_class_sub", 4'd8, 64'h00000001, 64'h0, 64'h020, 1'b0);
      check_sp("sp_class_snan", 4'd8, 64'h7FA00000, 64'h0, 64'h100, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
